mux2_1_arb: RTL and testbench

- Round-robin arbiter and sequencer for a shared 2:1 datapath mux: two requesters (A, B) each present a valid/ready/last burst stream.
- The block grants one requester at a time and drives the mux select, so that requester's beats reach a single downstream valid/ready port.
- A grant is held for a whole burst, until the beat carrying last is transferred.
- Sits between two producer blocks and one shared consumer.

---
 rtl/mux2_1_arb.sv | 133 +++++++++++++
 tb/tb_mux2_1_arb.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_1_arb.sv
// mux2_1_arb: round-robin arbiter that owns a shared 2:1 burst mux, holding each grant until last.
// Optional feature macro ARB_TIMEOUT_EN: caps a grant at MAX_BURST beats and adds the timeout_o pulse.
//
// state     | meaning
// S_IDLE    | no grant; arbitrate among pending requests (one cycle)
// S_GRANT_A | requester A owns the downstream port
// S_GRANT_B | requester B owns the downstream port
module mux2_1_arb #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_a,
    input  logic              a_valid,
    input  logic              a_last,
    output logic              a_ready,
    input  logic [DATA_W-1:0] data_b,
    input  logic              b_valid,
    input  logic              b_last,
    output logic              b_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              o_ready,
    output logic              sel,
    output logic              busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_A = 2'd1,
        S_GRANT_B = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sel;
    logic       w_sel_nxt;
    logic       r_last_served;
    logic       w_last_served_nxt;
    logic [7:0] r_beat_cnt;
    logic [7:0] w_beat_cnt_nxt;

    logic       w_xfer_a;
    logic       w_xfer_b;
    logic       w_xfer;
    logic       w_xfer_last;
    logic       w_timeout;

    assign w_xfer_a    = (r_state == S_GRANT_A) && a_valid && o_ready;
    assign w_xfer_b    = (r_state == S_GRANT_B) && b_valid && o_ready;
    assign w_xfer      = w_xfer_a || w_xfer_b;
    assign w_xfer_last = (w_xfer_a && a_last) || (w_xfer_b && b_last);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LIMIT = 8'(MAX_BURST - 1);

    // Forced release on the MAX_BURST-th beat of a grant when that beat is not last.
    assign w_timeout = w_xfer && !w_xfer_last && (r_beat_cnt == CNT_LIMIT);
    assign timeout_o = w_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel         <= 1'b0;
            r_last_served <= 1'b1;
            r_beat_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_last_served <= w_last_served_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_last_served_nxt = r_last_served;
        w_beat_cnt_nxt    = r_beat_cnt;
        o_valid           = 1'b0;
        a_ready           = 1'b0;
        b_ready           = 1'b0;

        case (r_state)
            S_IDLE: begin
                // last_served: 0 = A, 1 = B; a tie goes to whoever was not served last
                if (a_valid && (!b_valid || r_last_served)) begin
                    w_state_nxt = S_GRANT_A;
                    w_sel_nxt   = 1'b0;
                end else if (b_valid) begin
                    w_state_nxt = S_GRANT_B;
                    w_sel_nxt   = 1'b1;
                end
            end
            S_GRANT_A: begin
                o_valid = a_valid;
                a_ready = o_ready;
            end
            S_GRANT_B: begin
                o_valid = b_valid;
                b_ready = o_ready;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_xfer) begin
            if (w_xfer_last || w_timeout) begin
                w_state_nxt       = S_IDLE;
                w_last_served_nxt = w_xfer_b;
                w_beat_cnt_nxt    = 8'd0;
            end else if (r_beat_cnt != 8'hFF) begin
                w_beat_cnt_nxt = r_beat_cnt + 8'd1;
            end
        end
    end

    assign sel    = r_sel;
    assign busy   = (r_state != S_IDLE);
    assign o_data = r_sel ? data_b : data_a;
    assign o_last = r_sel ? b_last : a_last;

endmodule

// File: tb/tb_mux2_1_arb.sv
// Directed bench for mux2_1_arb: bench-side burst sources feed both requesters, transfers are logged
// and compared cycle by cycle against hand-derived sequences.
module tb_mux2_1_arb;

`ifdef ARB_TIMEOUT_EN
    localparam int MB = 4;
`else
    localparam int MB = 16;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         cyc;
        logic       sel;
        logic [7:0] data;
        logic       last;
    } log_t;

    logic       clk;
    logic       rst;
    logic [7:0] data_a;
    logic       a_valid;
    logic       a_last;
    logic       a_ready;
    logic [7:0] data_b;
    logic       b_valid;
    logic       b_last;
    logic       b_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       o_ready;
    logic       sel;
    logic       busy;
`ifdef ARB_TIMEOUT_EN
    logic       timeout_o;
`endif

    mux2_1_arb #(.DATA_W(8), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_a  (data_a),
        .a_valid (a_valid),
        .a_last  (a_last),
        .a_ready (a_ready),
        .data_b  (data_b),
        .b_valid (b_valid),
        .b_last  (b_last),
        .b_ready (b_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_ready (o_ready),
        .sel     (sel),
        .busy    (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    int    tcyc    = 0;
    logic  a_en    = 1'b0;
    logic  b_en    = 1'b0;
    beat_t qa[$];
    beat_t qb[$];
    logic  ordy_q[$];
    log_t  lg[$];
    logic  t_sel[$];
    logic  t_busy[$];
    logic  t_ov[$];
    logic  t_ar[$];
    logic  t_br[$];
    logic  t_to[$];

    task automatic clear_trace();
        lg.delete();
        t_sel.delete();
        t_busy.delete();
        t_ov.delete();
        t_ar.delete();
        t_br.delete();
        t_to.delete();
        tcyc = 0;
    endtask

    // One clock: present source heads, sample mid-cycle, retire accepted beats after the edge.
    task automatic step();
        logic acc_a;
        logic acc_b;
        a_valid = a_en && (qa.size() > 0);
        data_a  = a_valid ? qa[0].data : 8'h00;
        a_last  = a_valid ? qa[0].last : 1'b0;
        b_valid = b_en && (qb.size() > 0);
        data_b  = b_valid ? qb[0].data : 8'h00;
        b_last  = b_valid ? qb[0].last : 1'b0;
        o_ready = (ordy_q.size() > 0) ? ordy_q.pop_front() : 1'b1;
        @(negedge clk);
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        t_sel.push_back(sel);
        t_busy.push_back(busy);
        t_ov.push_back(o_valid);
        t_ar.push_back(a_ready);
        t_br.push_back(b_ready);
`ifdef ARB_TIMEOUT_EN
        t_to.push_back(timeout_o);
`else
        t_to.push_back(1'b0);
`endif
        if (!rst && o_valid && o_ready)
            lg.push_back('{tcyc, sel, o_data, o_last});
        @(posedge clk);
        #1;
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        tcyc++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        a_en = 1'b0;
        b_en = 1'b0;
        qa.delete();
        qb.delete();
        ordy_q.delete();
        step();
        step();
        rst = 1'b0;
        clear_trace();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        a_en = 1'b1;
        b_en = 1'b1;
        qa.delete();
        qb.delete();
        ordy_q.delete();
        clear_trace();
        qa.push_back('{8'h5A, 1'b1});
        qb.push_back('{8'hC3, 1'b1});
        step();
        step();
        n_tests++;
        if (t_ov[1] !== 1'b0 || t_sel[1] !== 1'b0 || t_busy[1] !== 1'b0 ||
            t_ar[1] !== 1'b0 || t_br[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b sel=%b busy=%b ar=%b br=%b required all 0",
                     t_ov[1], t_sel[1], t_busy[1], t_ar[1], t_br[1]);
        end
        rst = 1'b0;
        clear_trace();
        repeat (5) step();
        n_tests++;
        if (t_ov[0] !== 1'b0 || t_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_arb_cycle: got ov=%b busy=%b required 0 0", t_ov[0], t_busy[0]);
        end
        n_tests++;
        if (t_sel[1] !== 1'b0 || t_busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: got sel=%b busy=%b required 0 1", t_sel[1], t_busy[1]);
        end
        n_tests++;
        if (lg.size() != 2) begin
            n_fail++;
            $display("FAIL reset_beat_count: got %0d required 2", lg.size());
        end else begin
            n_tests++;
            if (lg[0].cyc != 1 || lg[0].data !== 8'h5A || lg[0].sel !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_first_beat: got cyc=%0d data=%h sel=%b required 1 5a 0",
                         lg[0].cyc, lg[0].data, lg[0].sel);
            end
            n_tests++;
            if (lg[1].cyc != 3 || lg[1].data !== 8'hC3 || lg[1].sel !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_second_beat: got cyc=%0d data=%h sel=%b required 3 c3 1",
                         lg[1].cyc, lg[1].data, lg[1].sel);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [7] = '{8'h11, 8'h22, 8'h33, 8'hA0, 8'hA1, 8'h44, 8'h55};
        logic       exp_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       exp_l [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int         exp_c [7] = '{1, 2, 3, 5, 6, 8, 10};
        do_reset();
        a_en = 1'b1;
        b_en = 1'b1;
        qa.push_back('{8'h11, 1'b0});
        qa.push_back('{8'h22, 1'b0});
        qa.push_back('{8'h33, 1'b1});
        qb.push_back('{8'hA0, 1'b0});
        qb.push_back('{8'hA1, 1'b1});
        repeat (7) step();
        qa.push_back('{8'h44, 1'b1});
        qb.push_back('{8'h55, 1'b1});
        repeat (4) step();
        n_tests++;
        if (lg.size() != 7) begin
            n_fail++;
            $display("FAIL rr_beat_count: got %0d required 7", lg.size());
        end
        for (int i = 0; i < 7 && i < lg.size(); i++) begin
            n_tests++;
            if (lg[i].data !== exp_d[i] || lg[i].sel !== exp_s[i] ||
                lg[i].last !== exp_l[i] || lg[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL rr_beat[%0d]: got data=%h sel=%b last=%b cyc=%0d required %h %b %b %0d",
                         i, lg[i].data, lg[i].sel, lg[i].last, lg[i].cyc,
                         exp_d[i], exp_s[i], exp_l[i], exp_c[i]);
            end
        end
        n_tests++;
        if (t_busy[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle_gap: got busy=%b required 0", t_busy[4]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [3]  = '{8'hB0, 8'hB1, 8'hB2};
        int         exp_c [3]  = '{1, 4, 5};
        logic       exp_br [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        b_en = 1'b1;
        qb.push_back('{8'hB0, 1'b0});
        qb.push_back('{8'hB1, 1'b0});
        qb.push_back('{8'hB2, 1'b1});
        ordy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (6) step();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (t_br[i] !== exp_br[i] || t_ar[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got b_ready=%b a_ready=%b required %b 0",
                         i, t_br[i], t_ar[i], exp_br[i]);
            end
        end
        n_tests++;
        if (lg.size() != 3) begin
            n_fail++;
            $display("FAIL bp_beat_count: got %0d required 3", lg.size());
        end
        for (int i = 0; i < 3 && i < lg.size(); i++) begin
            n_tests++;
            if (lg[i].data !== exp_d[i] || lg[i].sel !== 1'b1 || lg[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL bp_beat[%0d]: got data=%h sel=%b cyc=%0d required %h 1 %0d",
                         i, lg[i].data, lg[i].sel, lg[i].cyc, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_valid_gap();
        logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
        logic       exp_s [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int         exp_c [5] = '{1, 2, 6, 7, 9};
        do_reset();
        b_en = 1'b1;
        qa.push_back('{8'hA0, 1'b0});
        qa.push_back('{8'hA1, 1'b0});
        qa.push_back('{8'hA2, 1'b0});
        qa.push_back('{8'hA3, 1'b1});
        qb.push_back('{8'hB0, 1'b1});
        for (int i = 0; i < 11; i++) begin
            a_en = !(i >= 3 && i <= 5);
            step();
        end
        for (int i = 1; i <= 7; i++) begin
            n_tests++;
            if (t_sel[i] !== 1'b0 || t_busy[i] !== 1'b1 || t_br[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got sel=%b busy=%b b_ready=%b required 0 1 0",
                         i, t_sel[i], t_busy[i], t_br[i]);
            end
        end
        n_tests++;
        if (t_ov[3] !== 1'b0 || t_ov[4] !== 1'b0 || t_ov[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_ovalid: got %b%b%b required 000", t_ov[3], t_ov[4], t_ov[5]);
        end
        n_tests++;
        if (lg.size() != 5) begin
            n_fail++;
            $display("FAIL gap_beat_count: got %0d required 5", lg.size());
        end
        for (int i = 0; i < 5 && i < lg.size(); i++) begin
            n_tests++;
            if (lg[i].data !== exp_d[i] || lg[i].sel !== exp_s[i] || lg[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL gap_beat[%0d]: got data=%h sel=%b cyc=%0d required %h %b %0d",
                         i, lg[i].data, lg[i].sel, lg[i].cyc, exp_d[i], exp_s[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        a_en = 1'b1;
        b_en = 1'b1;
        qa.push_back('{8'h01, 1'b1});
        qa.push_back('{8'h03, 1'b1});
        qa.push_back('{8'h05, 1'b1});
        qb.push_back('{8'h02, 1'b1});
        qb.push_back('{8'h04, 1'b1});
        qb.push_back('{8'h06, 1'b1});
        repeat (12) step();
        n_tests++;
        if (lg.size() != 6) begin
            n_fail++;
            $display("FAIL single_beat_count: got %0d required 6", lg.size());
        end
        for (int i = 0; i < 6 && i < lg.size(); i++) begin
            n_tests++;
            if (lg[i].data !== 8'(i + 1) || lg[i].sel !== 1'(i % 2) || lg[i].cyc != 2 * i + 1) begin
                n_fail++;
                $display("FAIL single_beat[%0d]: got data=%h sel=%b cyc=%0d required %h %0d %0d",
                         i, lg[i].data, lg[i].sel, lg[i].cyc, 8'(i + 1), i % 2, 2 * i + 1);
            end
        end
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (t_busy[i] !== 1'(i % 2)) begin
                n_fail++;
                $display("FAIL single_busy[%0d]: got %b required %0d", i, t_busy[i], i % 2);
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp_d [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
        logic       exp_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int         exp_c [8] = '{1, 2, 3, 4, 6, 7, 9, 10};
        do_reset();
        a_en = 1'b1;
        b_en = 1'b1;
        for (int i = 0; i < 6; i++)
            qa.push_back('{8'(8'hA0 + i), (i == 5)});
        qb.push_back('{8'hB0, 1'b0});
        qb.push_back('{8'hB1, 1'b1});
        repeat (11) step();
        for (int i = 0; i < 11; i++) begin
            n_tests++;
            if (t_to[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL timeout_pulse[%0d]: got %b required %0d", i, t_to[i], (i == 4));
            end
        end
        n_tests++;
        if (lg.size() != 8) begin
            n_fail++;
            $display("FAIL timeout_beat_count: got %0d required 8", lg.size());
        end
        for (int i = 0; i < 8 && i < lg.size(); i++) begin
            n_tests++;
            if (lg[i].data !== exp_d[i] || lg[i].sel !== exp_s[i] || lg[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL timeout_beat[%0d]: got data=%h sel=%b cyc=%0d required %h %b %0d",
                         i, lg[i].data, lg[i].sel, lg[i].cyc, exp_d[i], exp_s[i], exp_c[i]);
            end
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_last  = 1'b0;
        b_last  = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        o_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_valid_gap();
        test_single_beat();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
